uart_rx16: RTL and testbench
============================

Name: uart_rx16

Overview:
- Receive side of the 16-bit switch-word UART link; recovers words sent as two back-to-back 8N1 frames, low byte first (D0..D7 then D8..D15), LSB first within each byte.
- Sits between the board RX pin and the LED/display logic.
- Oversamples the line with the system clock, centre-samples each bit, and presents one 16-bit word with a single-cycle valid strobe.

Parameters:
- CLOCK_SPEED, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- CLOCKS_PER_BIT, (CLOCK_SPEED/BAUD_RATE)+1: clocks per bit, matching the transmitter's derivation (10417 at defaults).
- GAP_TIMEOUT_BITS, 20: maximum idle time, in bit periods, allowed between the stop bit of the low frame and the start bit of the high frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- rxd  input  1  serial line from the pin, asynchronous, idles high.
- rx_data  output  16  last good word; updated only together with rx_valid.
- rx_valid  output  1  one-cycle pulse when rx_data has just been updated.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- busy  output  1  high from a validated start bit until the pair completes or is abandoned.

Behaviour:
- Reset (rst=0, asynchronous): rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, all counters 0. The synchronizer flops reset to 1 (line idle).
- rxd passes through a 2-flop synchronizer. A falling edge is "previous synced=1, current synced=0". All sampling uses the synced value.
- A 14-bit bit_cnt counts clocks while state != IDLE/GAP. bit_idx counts 0..7. hi_byte selects the frame (0=low, 1=high).
- The GAP state uses a separate gap_cnt, sized for GAP_TIMEOUT_BITS*CLOCKS_PER_BIT.
- IDLE:
  - Falling edge -> START, bit_cnt=0, hi_byte=0.
- START:
  - At bit_cnt == CLOCKS_PER_BIT/2-1, sample the line.
  - Sample low -> DATA, bit_cnt=0, bit_idx=0, busy=1.
  - Sample high -> treat as a glitch: back to IDLE (or back to GAP if hi_byte=1), no error pulse.
- DATA:
  - At bit_cnt == CLOCKS_PER_BIT-1 (the centre of each bit), shift the sample into the shift register at position bit_idx and reset bit_cnt.
  - After bit_idx 7, go to STOP.
- STOP:
  - At bit_cnt == CLOCKS_PER_BIT-1, sample the line.
  - Sample 0: frame_err pulses the next cycle, the pair is discarded, state -> IDLE, busy=0.
  - Sample 1 with hi_byte=0: latch the low byte, hi_byte=1, state -> GAP, gap_cnt=0.
  - Sample 1 with hi_byte=1: next cycle rx_data={high byte, low byte}, rx_valid=1 for one cycle, state -> IDLE, busy=0.
- GAP:
  - busy stays 1.
  - Falling edge -> START (hi_byte stays 1).
  - gap_cnt reaching GAP_TIMEOUT_BITS*CLOCKS_PER_BIT-1 first -> discard the low byte, state IDLE, busy=0, no pulses.
- Latency: rx_valid rises one clock after the centre sample of the second stop bit, i.e. about half a bit before the line stop bit ends.
- Back-to-back words: returning to IDLE at mid-stop means the next start edge is caught with no lost frames.
- A break condition (line held low) produces at most one frame_err, because IDLE requires a falling edge to restart.
- rx_valid and frame_err are never high in the same cycle.
- Reset asserted mid-frame aborts immediately; a partial word is never output.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every centre sample (start, data, stop) is the 2-of-3 majority of the synced line at bit_cnt = centre-1, centre, centre+1. The decision is taken at centre+1, and bit_cnt still wraps at CLOCKS_PER_BIT-1, so bit timing is unchanged and rx_valid moves one clock later.
- Undefined: single sample at the centre count. No extra flops.

Decomposition:
- Package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, STOP, GAP);
  - the CLOCKS_PER_BIT derivation function;
  - the frame constants (DATA_BITS=8, FRAMES_PER_WORD=2), shared with uart_tx.
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detector, with reset to 1. It is reused by any later RX-side block.

Test Plan (use CLOCK_SPEED=1_100_000, BAUD_RATE=100_000 -> CLOCKS_PER_BIT=12; GAP_TIMEOUT_BITS=20):
- Send 0xA55A as two clean frames (0x5A then 0xA5), no gap -> one rx_valid pulse, rx_data=16'hA55A, frame_err never high, busy low afterwards.
- 3-clock low glitch on an idle line -> no rx_valid, no frame_err, busy stays 0. Then send 0x1234 -> rx_data=16'h1234.
- Low frame with stop bit forced 0 -> exactly one frame_err pulse, no rx_valid, rx_data keeps its previous value (0x1234).
- Only the low frame 0x00FF sent, then idle -> busy drops 240 clocks after entering GAP, no pulses. Then send 0xBEEF -> rx_data=16'hBEEF.
- Pull rst low mid-way through the high frame of 0xCAFE, release, then send 0x0F0F -> outputs are 0 during reset, no spurious valid, then rx_data=16'h0F0F.
- With UART_RX_MAJORITY_EN defined, flip one clock at each bit centre of 0x5555 -> rx_data=16'h5555. Without the macro, the same stimulus shows corrupted bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period derivation
// and frame constants (also used by uart_tx).
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int FRAMES_PER_WORD = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } rx_state_e;

  // Same rounding as the transmitter so both ends agree on the bit period.
  function automatic int calc_clocks_per_bit(input int clock_speed, input int baud_rate);
    return (clock_speed / baud_rate) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial line, plus falling-edge
// detect on the synchronized value. All flops reset to 1 (idle line) so a
// reset release never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_sync,
  output logic rxd_fall
);

  logic meta, sync, prev;

  // Synchronizer chain and one-cycle history for the edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rxd;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rxd_sync = sync;
  assign rxd_fall = prev & ~sync;

endmodule

// File: rtl/uart_rx16.sv
// 16-bit word receiver: two back-to-back 8N1 frames, low byte first.
// Centre-samples each bit and emits the word with a one-cycle rx_valid.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around every
// centre sample; timing of all decisions moves one clock later.
module uart_rx16 import uart_pkg::*; #(
  parameter int CLOCK_SPEED      = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int CLOCKS_PER_BIT   = calc_clocks_per_bit(CLOCK_SPEED, BAUD_RATE),
  parameter int GAP_TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int GAP_CLKS = GAP_TIMEOUT_BITS * CLOCKS_PER_BIT;
  localparam int GAP_W    = $clog2(GAP_CLKS);
  localparam int IDX_W    = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DLY = 1;
`else
  localparam int MAJ_DLY = 0;
`endif

  // The start-bit decision point sets the phase for every later bit. With
  // the majority vote it sits one clock after the start centre, so the
  // bit_cnt wrap at CLOCKS_PER_BIT-1 lands on centre+1 of each later bit.
  localparam logic [13:0]      START_SMP = 14'(CLOCKS_PER_BIT / 2 - 1 + MAJ_DLY);
  localparam logic [13:0]      BIT_LAST  = 14'(CLOCKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rxd_sync, rxd_fall, sample_bit;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rxd_sync (rxd_sync),
    .rxd_fall (rxd_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Two previous synced samples; with the current one they form the vote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist <= 2'b11;
    else      hist <= {hist[0], rxd_sync};
  end

  assign sample_bit = (hist[1] & hist[0]) | (hist[1] & rxd_sync) | (hist[0] & rxd_sync);
`else
  assign sample_bit = rxd_sync;
`endif

  rx_state_e            state, state_nxt;
  logic [13:0]          bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic                 hi_byte, hi_byte_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [DATA_BITS-1:0] lo_byte, lo_byte_nxt;
  logic [15:0]          rx_data_nxt;
  logic                 rx_valid_nxt, frame_err_nxt, busy_nxt;

  // State and datapath registers; outputs are registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      bit_idx   <= '0;
      hi_byte   <= 1'b0;
      shift_reg <= '0;
      lo_byte   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      hi_byte   <= hi_byte_nxt;
      shift_reg <= shift_nxt;
      lo_byte   <= lo_byte_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and datapath decode for the frame-pair receiver.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt + 14'd1;
    gap_cnt_nxt   = gap_cnt;
    bit_idx_nxt   = bit_idx;
    hi_byte_nxt   = hi_byte;
    shift_nxt     = shift_reg;
    lo_byte_nxt   = lo_byte;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    busy_nxt      = busy;
    case (state)
      IDLE: begin
        bit_cnt_nxt = '0;
        if (rxd_fall) begin
          state_nxt   = START;
          hi_byte_nxt = 1'b0;
        end
      end
      START: begin
        if (bit_cnt == START_SMP) begin
          bit_cnt_nxt = '0;
          if (!sample_bit) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
            busy_nxt    = 1'b1;
          end else begin
            // Glitch: resume waiting for whichever frame was expected.
            state_nxt = hi_byte ? GAP : IDLE;
          end
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt          = '0;
          shift_nxt[bit_idx]   = sample_bit;
          bit_idx_nxt          = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt = '0;
          if (!sample_bit) begin
            frame_err_nxt = 1'b1;
            state_nxt     = IDLE;
            busy_nxt      = 1'b0;
            hi_byte_nxt   = 1'b0;
          end else if (!hi_byte) begin
            lo_byte_nxt = shift_reg;
            hi_byte_nxt = 1'b1;
            gap_cnt_nxt = '0;
            state_nxt   = GAP;
          end else begin
            // Leave at mid-stop so a following start edge is not missed.
            rx_data_nxt  = {shift_reg, lo_byte};
            rx_valid_nxt = 1'b1;
            state_nxt    = IDLE;
            busy_nxt     = 1'b0;
            hi_byte_nxt  = 1'b0;
          end
        end
      end
      GAP: begin
        bit_cnt_nxt = '0;
        gap_cnt_nxt = gap_cnt + GAP_W'(1);
        if (rxd_fall) begin
          state_nxt = START;
        end else if (gap_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          busy_nxt    = 1'b0;
          hi_byte_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx16.sv
// Directed bench for uart_rx16 at 12 clocks per bit.
module tb_uart_rx16;

  localparam int CPB = 12;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] rx_data;
  logic        rx_valid, frame_err, busy;

  int total = 0;
  int bad   = 0;

  // monitor state
  int cyc = 0, n_valid = 0, n_ferr = 0, n_both = 0, n_busy = 0;
  int valid_cyc = 0, busy_fall_cyc = 0;
  logic busy_q = 1'b0;
  logic [15:0] words_q[$];
  int frame_t0 = 0;

  uart_rx16 #(
    .CLOCK_SPEED(1_100_000),
    .BAUD_RATE(100_000),
    .GAP_TIMEOUT_BITS(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Sees pre-edge output values at every rising edge.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= busy;
    if (rx_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc + 1;
      words_q.push_back(rx_data);
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (rx_valid && frame_err) n_both <= n_both + 1;
    if (busy) n_busy <= n_busy + 1;
    if (busy_q && !busy) busy_fall_cyc <= cyc + 1;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd = 1'b1;
    end
  endtask

  // One 8N1 frame, one value per clock; flip inverts the middle clock of
  // each data bit; n_slots truncates the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic flip, input int n_slots);
    logic v;
    for (int k = 0; k < 10; k++) begin
      v = (k == 0) ? 1'b0 : (k == 9) ? stop_v : b[k-1];
      for (int c = 0; c < CPB; c++) begin
        if (k * CPB + c < n_slots) begin
          @(negedge clk);
          rxd = (flip && k >= 1 && k <= 8 && c == CPB / 2) ? ~v : v;
          if (k == 0 && c == 0) frame_t0 = cyc;
        end
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_frame(w[7:0], 1'b1, 1'b0, 120);
    send_frame(w[15:8], 1'b1, 1'b0, 120);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b1;
    idle(5);
  endtask

  task automatic test_basic;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_word(16'hA55A);
    idle(12);
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL basic_valid_count got=%0d exp=1", n_valid - v0); end
    total++; if (rx_data !== 16'hA55A) begin bad++; $display("FAIL basic_rx_data got=%h exp=a55a", rx_data); end
    total++; if (valid_cyc - frame_t0 !== 118 + MAJ) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", valid_cyc - frame_t0, 118 + MAJ); end
    total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL basic_frame_err got=%0d exp=0", n_ferr - f0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_glitch;
    int v0, f0, b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    repeat (3) begin @(negedge clk); rxd = 1'b0; end
    idle(30);
    total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", n_valid - v0); end
    total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL glitch_frame_err got=%0d exp=0", n_ferr - f0); end
    total++; if (n_busy - b0 !== 0) begin bad++; $display("FAIL glitch_busy_cycles got=%0d exp=0", n_busy - b0); end
    send_word(16'h1234);
    idle(12);
    total++; if (rx_data !== 16'h1234) begin bad++; $display("FAIL glitch_then_word got=%h exp=1234", rx_data); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h34, 1'b0, 1'b0, 120);
    idle(30);
    total++; if (n_ferr - f0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - f0); end
    total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL ferr_valid got=%0d exp=0", n_valid - v0); end
    total++; if (rx_data !== 16'h1234) begin bad++; $display("FAIL ferr_rx_data got=%h exp=1234", rx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy got=%b exp=0", busy); end
  endtask

  task automatic test_gap_timeout;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hFF, 1'b1, 1'b0, 120);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy_held got=%b exp=1", busy); end
    idle(300);
    total++; if (busy_fall_cyc - frame_t0 !== 358 + MAJ) begin bad++; $display("FAIL gap_busy_drop got=%0d exp=%0d", busy_fall_cyc - frame_t0, 358 + MAJ); end
    total++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin bad++; $display("FAIL gap_pulses got=%0d/%0d exp=0/0", n_valid - v0, n_ferr - f0); end
    send_word(16'hBEEF);
    idle(12);
    total++; if (rx_data !== 16'hBEEF) begin bad++; $display("FAIL gap_then_word got=%h exp=beef", rx_data); end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = n_valid;
    send_frame(8'hFE, 1'b1, 1'b0, 120);
    send_frame(8'hCA, 1'b1, 1'b0, 50);
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (rx_data !== 16'h0000 || rx_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got=%h/%b/%b/%b exp=0000/0/0/0", rx_data, rx_valid, frame_err, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(150);
    total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL midreset_spurious got=%0d exp=0", n_valid - v0); end
    send_word(16'h0F0F);
    idle(12);
    total++; if (rx_data !== 16'h0F0F || n_valid - v0 !== 1) begin bad++; $display("FAIL midreset_next_word got=%h cnt=%0d exp=0f0f cnt=1", rx_data, n_valid - v0); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    words_q.delete();
    send_word(16'h1357);
    send_word(16'h2468);
    idle(12);
    total++; if (n_valid - v0 !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n_valid - v0); end
    total++; if (words_q.size() != 2 || words_q[0] !== 16'h1357 || words_q[1] !== 16'h2468) begin
      bad++; $display("FAIL b2b_words got_n=%0d exp=1357,2468", words_q.size());
    end
  endtask

  task automatic test_majority;
    logic [15:0] exp_w;
    exp_w = (MAJ == 1) ? 16'h5555 : 16'hAAAA;
    send_frame(8'h55, 1'b1, 1'b1, 120);
    send_frame(8'h55, 1'b1, 1'b1, 120);
    idle(12);
    total++; if (rx_data !== exp_w) begin bad++; $display("FAIL majority_word got=%h exp=%h", rx_data, exp_w); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_gap_timeout();
    test_reset_mid();
    test_back_to_back();
    test_majority();
    total++; if (n_both !== 0) begin bad++; $display("FAIL valid_and_ferr_overlap got=%0d exp=0", n_both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
